// File: rtl/gate_response_checker_if.sv
// Bus between the gate-tile self-test checker and its surroundings.
//   start            : begin a stimulus sweep
//   stim_out         : stimulus driven into the gate under test
//   dut_resp         : response read back from the gate under test
//   busy/done/pass   : sweep status
//   err_count        : saturating mismatch count
//   first_fail_vec   : stimulus of the first mismatching vector
//   first_fail_valid : first_fail_vec holds a captured vector
// master = controller/tile side, slave = checker.
interface gate_response_checker_if;
   logic       start;
   logic [7:0] stim_out;
   logic [7:0] dut_resp;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [7:0] first_fail_vec;
   logic       first_fail_valid;

   modport master (
      output start, dut_resp,
      input  stim_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid
   );

   modport slave (
      input  start, dut_resp,
      output stim_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid
   );
endinterface

// File: rtl/gate_response_checker.sv
// On-chip self-test engine for small logic-gate tiles. Sweeps every
// stimulus vector 0 .. 2**STIM_W-1 into the gate, waits SETTLE+1 cycles,
// samples the response and compares it against an AND-gate golden model.
// Mismatches are counted (saturating) and the first failing vector kept.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : gate_response_checker_if slave modport (start, stim_out,
//          dut_resp, busy, done, pass, err_count, first_fail_vec,
//          first_fail_valid)
module gate_response_checker #(
   parameter int unsigned STIM_W    = 2,
   parameter int unsigned SETTLE    = 1,
   parameter logic [7:0]  RESP_MASK = 8'h01
) (
   input  logic                    clk,
   input  logic                    rst,
   gate_response_checker_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
   // 9-bit last-vector constant so STIM_W=8 never relies on counter wrap.
   localparam logic [8:0] LAST_VEC   = 9'((1 << STIM_W) - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] stim_q, stim_d;
   logic [7:0] err_q, err_d;
   logic [7:0] ffv_q, ffv_d;
   logic       ffvalid_q, ffvalid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;

   logic [7:0] exp_vec;
   logic       mismatch;

   assign exp_vec  = {7'b0, &stim_q[STIM_W-1:0]};
   assign mismatch = |((bus.dut_resp ^ exp_vec) & RESP_MASK);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stim_d    = stim_q;
      err_d     = err_q;
      ffv_d     = ffv_q;
      ffvalid_d = ffvalid_q;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               stim_d    = '0;
               err_d     = '0;
               ffv_d     = '0;
               ffvalid_d = 1'b0;
               cnt_d     = SETTLE_CNT;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = SAMPLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         SAMPLE: begin
            if (mismatch) begin
               if (err_q != 8'hFF) err_d = err_q + 8'd1;
               if (!ffvalid_q) begin
                  ffv_d     = stim_q;
                  ffvalid_d = 1'b1;
               end
            end
            if ({1'b0, stim_q} == LAST_VEC) begin
               state_d = DONE;
            end else begin
               stim_d  = stim_q + 8'd1;
               cnt_d   = SETTLE_CNT;
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase

      // Status flags are registered from the state being entered.
      busy_d = (state_d == WAIT) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
      pass_d = (state_d == DONE) && (err_d == 8'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         stim_q    <= '0;
         err_q     <= '0;
         ffv_q     <= '0;
         ffvalid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         stim_q    <= stim_d;
         err_q     <= err_d;
         ffv_q     <= ffv_d;
         ffvalid_q <= ffvalid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
      end
   end

   assign bus.stim_out         = stim_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.pass             = pass_q;
   assign bus.err_count        = err_q;
   assign bus.first_fail_vec   = ffv_q;
   assign bus.first_fail_valid = ffvalid_q;

endmodule
